// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: PS/2 frame receiver emitting ps2_key events; define PS2_NOREPEAT_EN to suppress typematic repeats
module ps2_key_encoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk_sys,
  input  logic        I_RESET_N,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC - 1);
  logic [1:0]    clk_sync, dat_sync;
  logic          clk_f, fall, frame_ok, byte_valid;
  logic [FW-1:0] flt_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shift;
  logic [7:0]    rx_byte;
  state_t        state, state_n;
  logic [2:0]    skip_cnt, skip_n;
  logic          emit, ext, pressed, ignored, suppress;
  // two-flop synchronisers for the asynchronous PS/2 lines
  always_ff @(posedge clk_sys) begin
    if (!I_RESET_N) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end
  assign fall     = clk_f & ~clk_sync[1] & (flt_cnt == FLT_MAX);
  assign frame_ok = ~shift[0] & dat_sync[1] & (^shift[9:1]);
  // filtered clock flips only after FILTER_LEN consecutive opposite samples
  always_ff @(posedge clk_sys) begin
    if (!I_RESET_N) begin
      clk_f   <= 1'b1;
      flt_cnt <= '0;
    end else if (clk_sync[1] == clk_f) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FLT_MAX) begin
      clk_f   <= ~clk_f;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end
  // frame shifter with framing/parity check and mid-frame timeout
  always_ff @(posedge clk_sys) begin
    if (!I_RESET_N) begin
      bit_cnt    <= '0;
      shift      <= '0;
      tmo_cnt    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tmo_cnt <= '0;
        shift   <= {dat_sync[1], shift[9:1]};
        if (bit_cnt == 4'd10) begin
          bit_cnt    <= '0;
          rx_byte    <= shift[8:1];
          byte_valid <= frame_ok;
          frame_err  <= ~frame_ok;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (tmo_cnt == TMO_MAX) begin
          bit_cnt   <= '0;
          tmo_cnt   <= '0;
          frame_err <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end
  // prefix state register
  always_ff @(posedge clk_sys) begin
    if (!I_RESET_N) begin
      state    <= IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_n;
      skip_cnt <= skip_n;
    end
  end
  assign ext     = (state == EXT) || (state == EXT_BRK);
  assign pressed = !((state == BRK) || (state == EXT_BRK));
  assign ignored = rx_byte inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  // prefix next-state and event decision on each valid byte
  always_comb begin
    state_n = state;
    skip_n  = skip_cnt;
    emit    = 1'b0;
    if (byte_valid) begin
      if (state == SKIP) begin
        skip_n  = skip_cnt - 3'd1;
        state_n = (skip_cnt == 3'd1) ? IDLE : SKIP;
      end else if (rx_byte == 8'hE0) begin
        state_n = (state == IDLE) ? EXT : (state == BRK) ? EXT_BRK : state;
      end else if (rx_byte == 8'hF0) begin
        state_n = (state == IDLE) ? BRK : (state == EXT) ? EXT_BRK : state;
      end else if (state == IDLE && rx_byte == 8'hE1) begin
        state_n = SKIP;
        skip_n  = 3'd7;
      end else if (!(state == IDLE && ignored)) begin
        emit    = 1'b1;
        state_n = IDLE;
      end
    end
  end
`ifdef PS2_NOREPEAT_EN
  logic [8:0] last_make;
  logic       last_vld;
  assign suppress = pressed & last_vld & (last_make == {ext, rx_byte});
  // remember the last make so a repeated identical make is dropped
  always_ff @(posedge clk_sys) begin
    if (!I_RESET_N) begin
      last_make <= '0;
      last_vld  <= 1'b0;
    end else if (emit) begin
      if (pressed) begin
        last_make <= {ext, rx_byte};
        last_vld  <= 1'b1;
      end else begin
        last_vld <= 1'b0;
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif
  // event output; bit 10 toggles once per emitted event
  always_ff @(posedge clk_sys) begin
    if (!I_RESET_N) ps2_key <= '0;
    else if (emit && !suppress) ps2_key <= {~ps2_key[10], pressed, ext, rx_byte};
  end
endmodule

// File: tb/tb_ps2_key_encoder.sv
// tb_ps2_key_encoder: directed PS/2 frames with a scoreboard of expected ps2_key events
module tb_ps2_key_encoder;
  localparam int HALF = 20;
  localparam int TMO  = 1000;
  logic        clk_sys = 1'b0;
  logic        I_RESET_N = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic [10:0] exp_q[$];
  logic [10:0] exp_w;
  logic        t = 1'b0;
  logic        key_prev = 1'b0;
  logic        mon_en = 1'b0;
  int          cyc = 0, stop_cyc = 0;
  int          tog_cnt = 0, err_cnt = 0, exp_tog = 0, exp_err = 0;
  int          n_chk = 0, n_fail = 0;

  ps2_key_encoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
    .clk_sys(clk_sys), .I_RESET_N(I_RESET_N), .ps2_clk(ps2_clk),
    .ps2_data(ps2_data), .ps2_key(ps2_key), .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // scoreboard: every bit-10 change pops one expected word and checks latency
  always @(posedge clk_sys) begin
    #1;
    if (mon_en) begin
      if (frame_err === 1'b1) err_cnt++;
      if (ps2_key[10] !== key_prev) begin
        key_prev = ps2_key[10];
        tog_cnt++;
        n_chk++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_event observed=%h expected=none", ps2_key);
        end
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          n_chk++;
          assert (ps2_key === exp_w) else begin
            n_fail++;
            $error("FAIL event_word observed=%h expected=%h", ps2_key, exp_w);
          end
          n_chk++;
          assert (cyc - stop_cyc == 11) else begin
            n_fail++;
            $error("FAIL event_latency observed=%0d expected=11", cyc - stop_cyc);
          end
        end
      end
    end
  end

  task automatic expect_ev(input logic p, input logic e, input logic [7:0] code);
    t = ~t;
    exp_q.push_back({t, p, e, code});
    exp_tog++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad, input int nbits);
    logic [10:0] f;
    f = {1'b1, ~(^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk_sys);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (HALF) @(negedge clk_sys);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk_sys);
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b0, 11);
  endtask

  task automatic check_step(input string tag);
    repeat (30) @(negedge clk_sys);
    n_chk++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL %s_pending observed=%0d expected=0", tag, exp_q.size());
    end
    n_chk++;
    assert (tog_cnt == exp_tog) else begin
      n_fail++;
      $error("FAIL %s_toggles observed=%0d expected=%0d", tag, tog_cnt, exp_tog);
    end
    n_chk++;
    assert (err_cnt == exp_err) else begin
      n_fail++;
      $error("FAIL %s_frame_err observed=%0d expected=%0d", tag, err_cnt, exp_err);
    end
    exp_q.delete();
  endtask

  initial begin
    repeat (5) @(negedge clk_sys);
    I_RESET_N = 1'b1;
    @(negedge clk_sys);
    n_chk++;
    assert (ps2_key === 11'h000) else begin
      n_fail++;
      $error("FAIL reset_key observed=%h expected=000", ps2_key);
    end
    n_chk++;
    assert (frame_err === 1'b0) else begin
      n_fail++;
      $error("FAIL reset_err observed=%b expected=0", frame_err);
    end
    key_prev = 1'b0;
    mon_en = 1'b1;

    expect_ev(1'b1, 1'b0, 8'h1C);
    send(8'h1C);
    check_step("make_1c");

    expect_ev(1'b1, 1'b1, 8'h75);
    send(8'hE0); send(8'h75);
    expect_ev(1'b0, 1'b1, 8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    check_step("ext_75");

    exp_err++;
    send_byte(8'h1C, 1'b1, 11);
    expect_ev(1'b1, 1'b0, 8'h1B);
    send(8'h1B);
    check_step("bad_parity");

    exp_err++;
    send_byte(8'h00, 1'b0, 5);
    repeat (TMO + 10) @(negedge clk_sys);
    expect_ev(1'b0, 1'b0, 8'h1C);
    send(8'hF0); send(8'h1C);
    check_step("timeout");

    ps2_clk = 1'b0;
    repeat (3) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (40) @(negedge clk_sys);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    expect_ev(1'b1, 1'b0, 8'h29);
    send(8'h29);
    check_step("glitch_pause");

    expect_ev(1'b1, 1'b0, 8'h1C);
    send(8'h1C);
`ifndef PS2_NOREPEAT_EN
    expect_ev(1'b1, 1'b0, 8'h1C);
    expect_ev(1'b1, 1'b0, 8'h1C);
`endif
    send(8'h1C); send(8'h1C);
    expect_ev(1'b0, 1'b0, 8'h1C);
    send(8'hF0); send(8'h1C);
    check_step("repeat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
